// File: rtl/loadable_instruction_memory_if.sv
// Fetch and byte-loader bus of the loadable instruction memory.
// The master side is the IF stage plus the program loader; the slave side is the memory.
interface loadable_instruction_memory_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]     Address;
  logic [31:0]     Instruction;
  logic            load_start;
  logic            load_end;
  logic            load_valid;
  logic [7:0]      load_byte;
  logic            load_ready;
  logic            cpu_hold;
  logic [ADDR_W:0] load_words;
  logic            load_overflow;

  modport master (
    output Address, load_start, load_end, load_valid, load_byte,
    input  Instruction, load_ready, cpu_hold, load_words, load_overflow
  );

  modport slave (
    input  Address, load_start, load_end, load_valid, load_byte,
    output Instruction, load_ready, cpu_hold, load_words, load_overflow
  );
endinterface

// File: rtl/loadable_instruction_memory.sv
// Runtime-loadable instruction RAM: bytes streamed over a valid/ready port are packed
// into 32-bit words; the core is held and sees NOP fetches while a load is in progress.
module loadable_instruction_memory #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  loadable_instruction_memory_if.slave bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_PTR = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [ADDR_W:0] ptr_r, ptr_s;
  logic [1:0]      phase_r, phase_s;
  logic [23:0]     asm_r, asm_s;
  logic            ovf_r, ovf_s;
  logic            ready_r, hold_r;
  logic            commit_s, we_s;
  logic [31:0]     word_s;
  logic [31:0]     instr_s;
  logic [31:0]     mem_r [DEPTH];

  // Words are assembled MSB-first; little-endian builds swap the bytes on commit.
  function automatic logic [31:0] order_word(input logic [31:0] be_word);
    if (BIG_ENDIAN) begin
      return be_word;
    end else begin
      return {be_word[7:0], be_word[15:8], be_word[23:16], be_word[31:24]};
    end
  endfunction

  // Left-justify a partial word so the missing trailing bytes are zero.
  function automatic logic [31:0] pad_word(input logic [23:0] asm_v, input logic [1:0] phase_v);
    case (phase_v)
      2'd1:    return {asm_v[7:0], 24'h000000};
      2'd2:    return {asm_v[15:0], 16'h0000};
      2'd3:    return {asm_v, 8'h00};
      default: return 32'h00000000;
    endcase
  endfunction

  // Next-state, byte assembly and word-commit decisions.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    phase_s  = phase_r;
    asm_s    = asm_r;
    ovf_s    = ovf_r;
    commit_s = 1'b0;
    word_s   = 32'h00000000;
    we_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (bus.load_start) begin
          state_s = ST_LOAD;
          ptr_s   = {(ADDR_W+1){1'b0}};
          phase_s = 2'd0;
          asm_s   = 24'h000000;
          ovf_s   = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (bus.load_start) begin
          // Restart discards any partial word and any byte offered this cycle.
          state_s = ST_LOAD;
          ptr_s   = {(ADDR_W+1){1'b0}};
          phase_s = 2'd0;
          asm_s   = 24'h000000;
          ovf_s   = 1'b0;
        end else begin
          if (bus.load_valid) begin
            if (phase_r == 2'd3) begin
              commit_s = 1'b1;
              word_s   = order_word({asm_r, bus.load_byte});
              phase_s  = 2'd0;
              asm_s    = 24'h000000;
            end else begin
              asm_s   = {asm_r[15:0], bus.load_byte};
              phase_s = phase_r + 2'd1;
            end
          end else begin
            phase_s = phase_r;
          end
          // End is judged against the phase after this cycle's byte.
          if (bus.load_end) begin
            state_s = (phase_s == 2'd0) ? ST_RUN : ST_PAD;
          end else begin
            state_s = ST_LOAD;
          end
        end
      end
      ST_PAD: begin
        commit_s = 1'b1;
        word_s   = order_word(pad_word(asm_r, phase_r));
        phase_s  = 2'd0;
        asm_s    = 24'h000000;
        state_s  = ST_RUN;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase

    if (commit_s) begin
      if (ptr_r == FULL_PTR) begin
        ovf_s = 1'b1;
        we_s  = 1'b0;
      end else begin
        we_s  = 1'b1;
        ptr_s = ptr_r + PTR_ONE;
      end
    end else begin
      we_s = 1'b0;
    end
  end

  // Control state; ready/hold are registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
      ptr_r   <= {(ADDR_W+1){1'b0}};
      phase_r <= 2'd0;
      asm_r   <= 24'h000000;
      ovf_r   <= 1'b0;
      ready_r <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      phase_r <= phase_s;
      asm_r   <= asm_s;
      ovf_r   <= ovf_s;
      ready_r <= (state_s == ST_LOAD);
      hold_r  <= (state_s != ST_RUN);
    end
  end

  // Program RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[ptr_r[ADDR_W-1:0]] <= word_s;
    end
  end

  // Asynchronous fetch; out-of-range addresses and held cycles return NOP.
  always_comb begin
    instr_s = 32'h00000000;
    if ((state_r == ST_RUN) && ((bus.Address >> (ADDR_W + 2)) == 32'h00000000)) begin
      instr_s = mem_r[bus.Address[ADDR_W+1:2]];
    end else begin
      instr_s = 32'h00000000;
    end
  end

  assign bus.Instruction   = instr_s;
  assign bus.load_ready    = ready_r;
  assign bus.cpu_hold      = hold_r;
  assign bus.load_words    = ptr_r;
  assign bus.load_overflow = ovf_r;
endmodule

// File: tb/tb_loadable_instruction_memory.sv
// Directed bench: a vector table drives the 256-word big-endian build, while a 4-word
// build and a little-endian build see the same stream and are checked by hand.
module tb_loadable_instruction_memory;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        st, en, vl;
  logic [7:0]  bt;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  loadable_instruction_memory_if #(.ADDR_W(8)) bus8 ();
  loadable_instruction_memory_if #(.ADDR_W(2)) bus2 ();
  loadable_instruction_memory_if #(.ADDR_W(8)) busl ();

  assign bus8.Address = addr; assign bus8.load_start = st; assign bus8.load_end = en;
  assign bus8.load_valid = vl; assign bus8.load_byte = bt;
  assign bus2.Address = addr; assign bus2.load_start = st; assign bus2.load_end = en;
  assign bus2.load_valid = vl; assign bus2.load_byte = bt;
  assign busl.Address = addr; assign busl.load_start = st; assign busl.load_end = en;
  assign busl.load_valid = vl; assign busl.load_byte = bt;

  loadable_instruction_memory #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) u8 (.clk(clk), .reset(reset), .bus(bus8));
  loadable_instruction_memory #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) u2 (.clk(clk), .reset(reset), .bus(bus2));
  loadable_instruction_memory #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) ul (.clk(clk), .reset(reset), .bus(busl));

  typedef struct {
    logic        st;
    logic        en;
    logic        vl;
    logic [7:0]  b;
    logic [31:0] a;
    logic        rdy;
    logic        hold;
    int          words;
    logic        ovf;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];
  int   seg_a_lo, seg_a_hi, seg_b_lo, seg_b_hi, seg_c_lo, seg_c_hi;
  logic [7:0] bytes_a [8] = '{8'h24, 8'h08, 8'h00, 8'h00, 8'h24, 8'h09, 8'h00, 8'h00};
  logic [7:0] bytes_b [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

  function automatic void add(input logic s, input logic e, input logic v, input logic [7:0] b,
                              input logic [31:0] a, input logic r, input logic h, input int w,
                              input logic o, input logic [31:0] ins);
    vec_t x;
    x.st = s; x.en = e; x.vl = v; x.b = b; x.a = a;
    x.rdy = r; x.hold = h; x.words = w; x.ovf = o; x.ins = ins;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic v, input logic [7:0] b,
                      input logic [31:0] a);
    st = s; en = e; vl = v; bt = b; addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(tbl[i].st, tbl[i].en, tbl[i].vl, tbl[i].b, tbl[i].a);
      chk($sformatf("vec%0d ready", i), 32'(bus8.load_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d hold", i), 32'(bus8.cpu_hold), 32'(tbl[i].hold));
      chk($sformatf("vec%0d words", i), 32'(bus8.load_words), 32'(tbl[i].words));
      chk($sformatf("vec%0d ovf", i), 32'(bus8.load_overflow), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d instr", i), bus8.Instruction, tbl[i].ins);
    end
  endtask

  initial begin
    // Basic two-word big-endian load and read-back.
    seg_a_lo = tbl.size();
    add(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b1, bytes_a[i], 32'h0, 1'b1, 1'b1, (i + 1) / 4, 1'b0, 32'h0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2, 1'b0, 32'h24080000);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h4, 1'b0, 1'b0, 2, 1'b0, 32'h24090000);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h400, 1'b0, 1'b0, 2, 1'b0, 32'h0);
    seg_a_hi = tbl.size();
    // Six bytes then end: one PAD cycle, second word zero-filled.
    seg_b_lo = tbl.size();
    add(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 1'b1, bytes_b[i], 32'h0, 1'b1, 1'b1, (i + 1) / 4, 1'b0, 32'h0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1, 1'b0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2, 1'b0, 32'hAABBCCDD);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h4, 1'b0, 1'b0, 2, 1'b0, 32'h11220000);
    seg_b_hi = tbl.size();
    // Gapped stream with load_end on the 8th byte; fetches are NOP throughout hold.
    seg_c_lo = tbl.size();
    add(1'b1, 1'b0, 1'b0, 8'h00, 32'h8, 1'b1, 1'b1, 0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        add(1'b0, 1'b1, 1'b1, 8'hC7, 32'h4, 1'b0, 1'b0, 2, 1'b0, 32'hC4C5C6C7);
      end else begin
        add(1'b0, 1'b0, 1'b1, 8'(8'hC0 + k), 32'(k * 4), 1'b1, 1'b1, (k + 1) / 4, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 8'hEE, 32'h3FC, 1'b1, 1'b1, (k + 1) / 4, 1'b0, 32'h0);
      end
    end
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2, 1'b0, 32'hC0C1C2C3);
    seg_c_hi = tbl.size();

    st = 1'b0; en = 1'b0; vl = 1'b0; bt = 8'h00; addr = 32'h400;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(bus8.load_ready), 32'h0);
    chk("rst hold", 32'(bus8.cpu_hold), 32'h0);
    chk("rst words", 32'(bus8.load_words), 32'h0);
    chk("rst ovf", 32'(bus2.load_overflow), 32'h0);
    chk("rst instr", bus8.Instruction, 32'h0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'h400);

    run_vecs(seg_a_lo, seg_a_hi);
    addr = 32'h0; #1;
    chk("le w0 basic", busl.Instruction, 32'h00000824);
    chk("aw2 w0 basic", bus2.Instruction, 32'h24080000);
    chk("aw2 words basic", 32'(bus2.load_words), 32'h2);

    run_vecs(seg_b_lo, seg_b_hi);
    addr = 32'h0; #1;
    chk("le w0 pad", busl.Instruction, 32'hDDCCBBAA);
    addr = 32'h4; #1;
    chk("le w1 pad", busl.Instruction, 32'h00002211);
    chk("le words pad", 32'(busl.load_words), 32'h2);

    // Five words into a 4-word memory.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 1'b1, 8'(w * 4 + j + 1), 32'h0);
      if (w == 3) chk("aw2 ovf at full", 32'(bus2.load_overflow), 32'h0);
    end
    chk("aw2 words sat", 32'(bus2.load_words), 32'h4);
    chk("aw2 ovf set", 32'(bus2.load_overflow), 32'h1);
    chk("aw8 words 5", 32'(bus8.load_words), 32'h5);
    chk("aw8 ovf clear", 32'(bus8.load_overflow), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    chk("aw2 hold end", 32'(bus2.cpu_hold), 32'h0);
    chk("aw2 w0 kept", bus2.Instruction, 32'h01020304);
    addr = 32'h10; #1;
    chk("aw8 w4", bus8.Instruction, 32'h11121314);
    chk("aw2 out of range", bus2.Instruction, 32'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("aw2 ovf cleared", 32'(bus2.load_overflow), 32'h0);
    chk("aw2 words restart", 32'(bus2.load_words), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    chk("aw2 empty load hold", 32'(bus2.cpu_hold), 32'h0);
    chk("aw2 w0 persists", bus2.Instruction, 32'h01020304);

    run_vecs(seg_c_lo, seg_c_hi);
    chk("le w0 gaps", busl.Instruction, 32'hC3C2C1C0);

    // Asynchronous reset after six bytes.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 32'h0);
    chk("pre-rst words", 32'(bus8.load_words), 32'h1);
    vl = 1'b0;
    reset = 1'b1; #1;
    chk("async rst hold", 32'(bus8.cpu_hold), 32'h0);
    chk("async rst ready", 32'(bus8.load_ready), 32'h0);
    chk("async rst words", 32'(bus8.load_words), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("rst w0 kept", bus8.Instruction, 32'hD0D1D2D3);
    addr = 32'h4; #1;
    chk("rst w1 unchanged", bus8.Instruction, 32'hC4C5C6C7);

    // load_start with a valid byte in RUN must not take that byte.
    step(1'b1, 1'b0, 1'b1, 8'h77, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hA0 + i), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    chk("start byte dropped hold", 32'(bus8.cpu_hold), 32'h0);
    chk("start byte dropped w0", bus8.Instruction, 32'hA0A1A2A3);

    // Restart after six bytes; the byte offered with the restart is discarded.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hE0 + i), 32'h0);
    step(1'b1, 1'b0, 1'b1, 8'hFF, 32'h0);
    chk("restart words", 32'(bus8.load_words), 32'h0);
    chk("restart hold", 32'(bus8.cpu_hold), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h90 + i), 32'h0);
    chk("restart words 1", 32'(bus8.load_words), 32'h1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    chk("restart w0", bus8.Instruction, 32'h90919293);
    addr = 32'h4; #1;
    chk("restart w1", bus8.Instruction, 32'hC4C5C6C7);

    // Fill all 256 words and probe the top of the address range.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'hA5, 32'h0);
      step(1'b0, 1'b0, 1'b1, ~8'(i), 32'h0);
      step(1'b0, 1'b0, 1'b1, 8'h3C, 32'h0);
      step(1'b0, 1'b0, 1'b1, 8'(i), 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 32'h3FC);
    chk("full words", 32'(bus8.load_words), 32'h100);
    chk("full ovf", 32'(bus8.load_overflow), 32'h0);
    chk("full w255", bus8.Instruction, 32'hA5003CFF);
    chk("aw2 full ovf", 32'(bus2.load_overflow), 32'h1);
    addr = 32'h3F8; #1;
    chk("full w254", bus8.Instruction, 32'hA5013CFE);
    addr = 32'h400; #1;
    chk("addr 0x400", bus8.Instruction, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loadable_instruction_memory.md
# loadable_instruction_memory

Parametrised, runtime-loadable instruction memory for the 5-stage MIPS pipeline. Program words are streamed in byte-by-byte through a valid/ready loader port and written into internal RAM, so new string-search programs load without resynthesis. While a load is in progress the core is held and fetches return NOP. Fetch is an asynchronous word read of the byte address supplied by the IF stage.

## Interface
- ADDR_W, 8: log2 of depth in 32-bit words (DEPTH = 2^ADDR_W).
- BIG_ENDIAN, 1: 1 = first streamed byte goes to Instruction[31:24]; 0 = first byte goes to [7:0].

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Address  in  32  fetch byte address; word index = Address[ADDR_W+1:2].
- Instruction  out  32  fetched word (combinational).
- load_start  in  1  single-cycle pulse; begins/restarts a load at word 0.
- load_end  in  1  single-cycle pulse; terminates the current load.
- load_valid  in  1  load_byte is valid.
- load_byte  in  8  program byte.
- load_ready  out  1  loader accepts a byte this cycle.
- cpu_hold  out  1  pipeline stall request.
- load_words  out  ADDR_W+1  words written by current/last load.
- load_overflow  out  1  sticky; a word was dropped because memory was full.

## Operation
- States: RUN, LOAD, PAD. Reset -> RUN.
- RUN: load_ready=0, cpu_hold=0. Instruction = mem[index] if Address[31:ADDR_W+2]==0, else 32'h0. load_start -> LOAD.
- LOAD: load_ready=1, cpu_hold=1, Instruction=32'h0.
  - Byte is accepted on an edge where load_valid && load_ready. Accepted bytes go into a 24-bit assembly register; the 2-bit phase increments.
  - When the 4th byte is accepted (phase 3), the word {assembly, byte} (byte-reversed if BIG_ENDIAN=0) is written to mem[ptr] on that edge, ptr increments, and phase returns to 0.
  - If ptr==DEPTH, the write is dropped, load_overflow is set, and ptr saturates at DEPTH.
  - load_end with phase==0 -> RUN. load_end with phase!=0 -> PAD.
  - load_start in LOAD restarts: ptr=0, phase=0, overflow cleared, partial bytes discarded. Any byte presented in the same cycle is discarded.
- PAD: load_ready=0, cpu_hold=1. Writes the partial word with missing low-order positions zero-filled (high-order positions if BIG_ENDIAN=0), subject to the same overflow rule. ptr increments, phase=0, then -> RUN. load_start and load_end are ignored in PAD.
- Same-cycle load_valid+load_end in LOAD: the byte is accepted first, then the end is evaluated against the updated phase. If that byte completes a word, the result is phase 0 and the next state is RUN.
- load_start in RUN with load_valid: the byte is not accepted, because load_ready=0 that cycle.
- load_words = ptr, updated live during the load and held in RUN.
- Memory contents are not reset. Words written before a reset or restart persist.

## Timing
- Reset values: state RUN, ptr 0, phase 0, load_words 0, load_overflow 0, load_ready 0, cpu_hold 0. Instruction follows the RUN read of the current Address.
- Reset mid-load: asserted asynchronously, it returns to RUN immediately. The partial word is lost and completed words are retained.
- load_start sampled at edge k: load_ready and cpu_hold go high after k.
- Write latency: a word written at edge k is visible on Instruction once RUN is re-entered.
- End, phase 0: load_end at edge k -> cpu_hold low after k.
- End, phase !=0: load_end at edge k -> PAD. The write happens at edge k+1, and cpu_hold goes low after k+1.
- Throughput: one byte per cycle; one word per 4 accepted bytes.

## Test plan
- Reset, load_start, bytes 24 08 00 00 24 09 00 00 back-to-back, load_end -> load_words=2, cpu_hold low the cycle after end, Address=0 -> 0x24080000, Address=4 -> 0x24090000.
- Bytes AA BB CC DD 11 22 then load_end -> PAD one cycle, mem[1]=0x11220000, load_words=2; the BIG_ENDIAN=0 build gives mem[0]=0xDDCCBBAA, mem[1]=0x00002211.
- ADDR_W=2, stream 5 words -> load_words=4, load_overflow=1, mem[0] keeps word 0. A new load_start clears overflow.
- load_valid toggled with gaps, load_end on the same cycle as the 8th byte -> exactly 2 words, no PAD. Instruction=0 for every Address throughout hold.
- Reset after 6 bytes -> state RUN, load_words=0, mem[0] holds word 0, mem[1] unchanged. Separately, load_start after 6 bytes -> ptr 0, next 4 bytes overwrite mem[0].
- ADDR_W=8, Address=0x400 in RUN -> Instruction=0; Address=0x3FC -> mem[255].
